synapse_fanout_fetch: RTL and testbench

- Parametrised successor to the single-weight synapse memory controller.
- For each pre-synaptic spike address popped from the spike address FIFO, it fetches FANOUT consecutive weights from synapse memory.
- The memory read latency is configurable (MEM_LAT) and the weight output uses a valid/ready handshake with backpressure.
- Sits between spike_addr_fifo and synapse_memory on one side and the neuron update array on the other.

---
 rtl/synapse_fanout_fetch.sv | 186 ++++++++++++++++++
 tb/tb_synapse_fanout_fetch.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synapse_fanout_fetch.sv
// Fetches FANOUT consecutive synapse weights for every spike address popped from the FIFO,
// with a credit-limited MEM_LAT-deep read pipeline and a valid/ready output. SYN_SKIP_ZERO_EN drops zero weights.
module synapse_fanout_fetch #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14,
    parameter int PRE_WIDTH  = 14,
    parameter int FANOUT     = 4,
    parameter int POST_WIDTH = 8,
    parameter int MEM_LAT    = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start_fetch,
    input  logic [PRE_WIDTH-1:0]  i_spike_addr_fifo_data,
    input  logic                  i_spike_addr_fifo_valid,
    output logic                  o_spike_addr_fifo_rden,
    output logic [ADDR_WIDTH-1:0] o_syn_mem_addr,
    output logic                  o_syn_mem_rden,
    input  logic [DATA_WIDTH-1:0] i_syn_mem_rdata,
    output logic                  o_weight_valid,
    input  logic                  i_weight_ready,
    output logic [DATA_WIDTH-1:0] o_weight_data,
    output logic [PRE_WIDTH-1:0]  o_weight_pre_addr,
    output logic [POST_WIDTH-1:0] o_weight_post_idx,
    output logic [CNT_WIDTH-1:0]  o_weight_count,
    output logic                  o_busy,
    output logic                  o_fetch_done
);

    localparam int OB_DEPTH = MEM_LAT + 2;
    localparam int PTR_W    = $clog2(OB_DEPTH);
    localparam int OCC_W    = $clog2(OB_DEPTH + 1);
    localparam int FLT_W    = $clog2(MEM_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [PRE_WIDTH-1:0]  pre;
        logic [POST_WIDTH-1:0] post;
    } tag_t;

    state_t                 state_q, state_d;
    logic [PRE_WIDTH-1:0]   cur_pre_q, cur_pre_d;
    logic [POST_WIDTH-1:0]  j_q, j_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [MEM_LAT-1:0]     pipe_vld_q, pipe_vld_d;
    tag_t                   pipe_tag_q [MEM_LAT];
    tag_t                   pipe_tag_d [MEM_LAT];
    logic [FLT_W-1:0]       in_flight_q, in_flight_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       ob_cnt_q, ob_cnt_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]  ob_data_q [OB_DEPTH];
    tag_t                   ob_tag_q  [OB_DEPTH];

    logic                   credit, issue, ret, ob_wr, ob_valid, xfer, fifo_rden;
    logic [ADDR_WIDTH-1:0]  pre_ext, fan_ext;
    tag_t                   ret_tag;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reserving a buffer slot at issue time means backpressure can never overflow the buffer.
    assign credit   = (int'(in_flight_q) + int'(ob_cnt_q)) < OB_DEPTH;
    assign issue    = (state_q == S_ISSUE) && credit;
    assign ret      = pipe_vld_q[MEM_LAT-1];
    assign ret_tag  = pipe_tag_q[MEM_LAT-1];
    assign ob_valid = (ob_cnt_q != '0);
    assign xfer     = ob_valid && i_weight_ready;

`ifdef SYN_SKIP_ZERO_EN
    assign ob_wr = ret && (i_syn_mem_rdata != '0);
`else
    assign ob_wr = ret;
`endif

    assign pre_ext = ADDR_WIDTH'(i_spike_addr_fifo_data);
    assign fan_ext = ADDR_WIDTH'(FANOUT);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d     = state_q;
        cur_pre_d   = cur_pre_q;
        j_d         = j_q;
        addr_d      = addr_q;
        count_d     = count_q;
        fifo_rden   = 1'b0;
        pipe_vld_d  = '0;
        wr_ptr_d    = ob_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = xfer  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        ob_cnt_d    = ob_cnt_q + OCC_W'(ob_wr) - OCC_W'(xfer);
        in_flight_d = in_flight_q + FLT_W'(issue) - FLT_W'(ret);

        pipe_vld_d[0]      = issue;
        pipe_tag_d[0].pre  = cur_pre_q;
        pipe_tag_d[0].post = j_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end

        if (xfer) count_d = count_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (i_start_fetch) begin
                    count_d = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_spike_addr_fifo_valid) begin
                    fifo_rden = 1'b1;
                    cur_pre_d = i_spike_addr_fifo_data;
                    j_d       = '0;
                    addr_d    = ADDR_WIDTH'(pre_ext * fan_ext);
                    state_d   = S_ISSUE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    j_d    = j_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (j_q == POST_WIDTH'(FANOUT - 1)) state_d = S_LOAD;
                end
            end
            S_DRAIN: begin
                if (in_flight_q == '0 && ob_cnt_q == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_pre_q   <= '0;
            j_q         <= '0;
            addr_q      <= '0;
            pipe_vld_q  <= '0;
            in_flight_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ob_cnt_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < MEM_LAT; i++) pipe_tag_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cur_pre_q   <= cur_pre_d;
            j_q         <= j_d;
            addr_q      <= addr_d;
            pipe_vld_q  <= pipe_vld_d;
            in_flight_q <= in_flight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ob_cnt_q    <= ob_cnt_d;
            count_q     <= count_d;
            for (int i = 0; i < MEM_LAT; i++) pipe_tag_q[i] <= pipe_tag_d[i];
        end
    end

    // NOTE: buffer storage is not reset; the reset pointers and occupancy make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (ob_wr) begin
            ob_data_q[wr_ptr_q] <= i_syn_mem_rdata;
            ob_tag_q[wr_ptr_q]  <= ret_tag;
        end
    end

    assign o_spike_addr_fifo_rden = fifo_rden;
    assign o_syn_mem_rden         = issue;
    assign o_syn_mem_addr         = issue ? addr_q : '0;
    assign o_weight_valid         = ob_valid;
    assign o_weight_data          = ob_valid ? ob_data_q[rd_ptr_q] : '0;
    assign o_weight_pre_addr      = ob_valid ? ob_tag_q[rd_ptr_q].pre : '0;
    assign o_weight_post_idx      = ob_valid ? ob_tag_q[rd_ptr_q].post : '0;
    assign o_weight_count         = count_q;
    assign o_busy                 = (state_q != S_IDLE);
    assign o_fetch_done           = (state_q == S_DONE);

endmodule

// File: tb/tb_synapse_fanout_fetch.sv
// Self-checking bench for synapse_fanout_fetch: FIFO and memory models, a queue scoreboard
// built from the addressing rule, and randomized backpressure.
module tb_synapse_fanout_fetch;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 14;
    localparam int PRE_WIDTH  = 14;
    localparam int FANOUT     = 4;
    localparam int POST_WIDTH = 8;
    localparam int MEM_LAT    = 3;
    localparam int CNT_WIDTH  = 16;
    localparam int OUT_W      = 1 + 1 + ADDR_WIDTH + 1 + DATA_WIDTH + PRE_WIDTH + POST_WIDTH + CNT_WIDTH + 1 + 1;
    localparam int HOLD_W     = 1 + DATA_WIDTH + PRE_WIDTH + POST_WIDTH;

    typedef struct { int data; int pre; int post; } wexp_t;

    logic                  clk;
    logic                  rst_n;
    logic                  i_start_fetch;
    logic [PRE_WIDTH-1:0]  i_spike_addr_fifo_data;
    logic                  i_spike_addr_fifo_valid;
    logic                  o_spike_addr_fifo_rden;
    logic [ADDR_WIDTH-1:0] o_syn_mem_addr;
    logic                  o_syn_mem_rden;
    logic [DATA_WIDTH-1:0] i_syn_mem_rdata;
    logic                  o_weight_valid;
    logic                  i_weight_ready;
    logic [DATA_WIDTH-1:0] o_weight_data;
    logic [PRE_WIDTH-1:0]  o_weight_pre_addr;
    logic [POST_WIDTH-1:0] o_weight_post_idx;
    logic [CNT_WIDTH-1:0]  o_weight_count;
    logic                  o_busy;
    logic                  o_fetch_done;

    synapse_fanout_fetch #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .PRE_WIDTH(PRE_WIDTH), .FANOUT(FANOUT),
        .POST_WIDTH(POST_WIDTH), .MEM_LAT(MEM_LAT), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start_fetch(i_start_fetch),
        .i_spike_addr_fifo_data(i_spike_addr_fifo_data), .i_spike_addr_fifo_valid(i_spike_addr_fifo_valid),
        .o_spike_addr_fifo_rden(o_spike_addr_fifo_rden), .o_syn_mem_addr(o_syn_mem_addr),
        .o_syn_mem_rden(o_syn_mem_rden), .i_syn_mem_rdata(i_syn_mem_rdata),
        .o_weight_valid(o_weight_valid), .i_weight_ready(i_weight_ready), .o_weight_data(o_weight_data),
        .o_weight_pre_addr(o_weight_pre_addr), .o_weight_post_idx(o_weight_post_idx),
        .o_weight_count(o_weight_count), .o_busy(o_busy), .o_fetch_done(o_fetch_done)
    );

    int    checks = 0;
    int    errors = 0;
    wexp_t exp_w[$];
    int    exp_addr[$];
    int    fifo_q[$];
    int    ready_mode = 0;
    int    pat_idx = 0;
    int    zero_addr = -1;
    bit    mon_en = 0;
    int    cyc = 0;
    int    xfers = 0;
    int    first_rd = -1;
    int    last_rd = -1;
    int    first_vld = -1;
    logic  stalled_prev = 1'b0;
    logic [HOLD_W-1:0]     held;
    logic [DATA_WIDTH-1:0] rd_pipe [MEM_LAT];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] mem_val(input int a);
        logic [31:0] av;
        av = a;
        if (a == zero_addr) return 8'h00;
        return av[7:0] ^ 8'h5A;
    endfunction

    task automatic fifo_refresh();
        i_spike_addr_fifo_valid = (fifo_q.size() != 0);
        i_spike_addr_fifo_data  = (fifo_q.size() != 0) ? PRE_WIDTH'(fifo_q[0]) : '0;
    endtask

    // Memory returns data MEM_LAT cycles after the issue cycle; idle slots carry junk.
    always @(posedge clk) begin
        rd_pipe[0] <= o_syn_mem_rden ? mem_val(int'(o_syn_mem_addr)) : 8'hEE;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (o_spike_addr_fifo_rden && fifo_q.size() > 0) fifo_q.delete(0);
    end
    assign i_syn_mem_rdata = rd_pipe[MEM_LAT-1];

    always @(negedge clk) begin
        wexp_t w;
        int    e;
        fifo_refresh();
        case (ready_mode)
            0: i_weight_ready = 1'b1;
            1: begin
                i_weight_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
                pat_idx++;
            end
            default: i_weight_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        cyc++;
        if (mon_en) begin
            if (o_syn_mem_rden) begin
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL mem_read: unexpected read addr %0d, none required", o_syn_mem_addr);
                end else begin
                    e = exp_addr.pop_front();
                    if (int'(o_syn_mem_addr) !== e) begin
                        errors++;
                        $display("FAIL mem_addr: got %0d required %0d", o_syn_mem_addr, e);
                    end
                end
            end
            if (stalled_prev) begin
                checks++;
                if ({o_weight_valid, o_weight_data, o_weight_pre_addr, o_weight_post_idx} !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got %h required %h", {o_weight_valid, o_weight_data,
                             o_weight_pre_addr, o_weight_post_idx}, held);
                end
            end
            if (o_weight_valid && first_vld < 0) first_vld = cyc;
            if (o_weight_valid && i_weight_ready) begin
                checks++;
                xfers++;
                if (exp_w.size() == 0) begin
                    errors++;
                    $display("FAIL weight: unexpected weight %h pre %0d post %0d", o_weight_data,
                             o_weight_pre_addr, o_weight_post_idx);
                end else begin
                    w = exp_w.pop_front();
                    if (o_weight_data !== DATA_WIDTH'(w.data) || o_weight_pre_addr !== PRE_WIDTH'(w.pre) ||
                        o_weight_post_idx !== POST_WIDTH'(w.post)) begin
                        errors++;
                        $display("FAIL weight: got %h/%0d/%0d required %h/%0d/%0d", o_weight_data,
                                 o_weight_pre_addr, o_weight_post_idx, w.data, w.pre, w.post);
                    end
                end
            end
            stalled_prev = o_weight_valid && !i_weight_ready;
            held = {o_weight_valid, o_weight_data, o_weight_pre_addr, o_weight_post_idx};
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // Expected reads and weights straight from the addressing rule.
    task automatic push_spike(input int p);
        int a;
        logic [7:0] d;
        fifo_q.push_back(p);
        for (int j = 0; j < FANOUT; j++) begin
            a = (p * FANOUT + j) % (1 << ADDR_WIDTH);
            d = mem_val(a);
            exp_addr.push_back(a);
`ifdef SYN_SKIP_ZERO_EN
            if (d == 8'h00) continue;
`endif
            exp_w.push_back('{int'(d), p, j});
        end
        fifo_refresh();
    endtask

    function automatic logic [OUT_W-1:0] all_outs();
        return {o_spike_addr_fifo_rden, o_syn_mem_rden, o_syn_mem_addr, o_weight_valid, o_weight_data,
                o_weight_pre_addr, o_weight_post_idx, o_weight_count, o_busy, o_fetch_done};
    endfunction

    task automatic run_fetch(input string name, input int n_exp);
        int waited = 0;
        xfers = 0;
        tick();
        i_start_fetch = 1'b1;
        tick();
        i_start_fetch = 1'b0;
        while (!o_fetch_done && waited < 2000) begin
            tick();
            waited++;
        end
        checks++;
        if (o_fetch_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: o_fetch_done=%0b after %0d cycles, required 1", name, o_fetch_done, waited);
        end
        checks++;
        if (o_weight_count !== CNT_WIDTH'(n_exp) || xfers != n_exp || exp_w.size() != 0 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL %s_count: count=%0d xfers=%0d pending_w=%0d pending_rd=%0d required count=%0d",
                     name, o_weight_count, xfers, exp_w.size(), exp_addr.size(), n_exp);
        end
        tick();
        checks++;
        if (o_fetch_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: done=%0b busy=%0b required 0/0", name, o_fetch_done, o_busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_start_fetch = 1'b0;
        i_weight_ready = 1'b1;
        fifo_refresh();
        repeat (3) tick();
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h required 0", all_outs());
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        ready_mode = 0;
        first_rd = -1;
        first_vld = -1;
        push_spike(10);
        push_spike(20);
        push_spike(30);
        run_fetch("basic", 12);
        checks++;
        if (first_vld - first_rd != MEM_LAT + 1) begin
            errors++;
            $display("FAIL latency: got %0d cycles required %0d", first_vld - first_rd, MEM_LAT + 1);
        end
        checks++;
        if (last_rd - first_rd != 3 * (FANOUT + 1) - 2) begin
            errors++;
            $display("FAIL throughput: issue span %0d cycles required %0d", last_rd - first_rd, 3 * (FANOUT + 1) - 2);
        end
    endtask

    task automatic test_backpressure();
        ready_mode = 1;
        pat_idx = 0;
        push_spike(10);
        push_spike(20);
        push_spike(30);
        run_fetch("stall", 12);
        ready_mode = 0;
    endtask

    task automatic test_empty_start();
        tick();
        i_start_fetch = 1'b1;
        tick();
        i_start_fetch = 1'b0;
        checks++;
        if (o_fetch_done !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL empty_c1: done=%0b busy=%0b required 0/1", o_fetch_done, o_busy);
        end
        tick();
        fifo_q.push_back(5);
        fifo_refresh();
        checks++;
        if (o_fetch_done !== 1'b0) begin
            errors++;
            $display("FAIL empty_c2: done=%0b required 0", o_fetch_done);
        end
        tick();
        checks++;
        if (o_fetch_done !== 1'b1 || o_weight_count !== '0) begin
            errors++;
            $display("FAIL empty_c3: done=%0b count=%0d required 1/0", o_fetch_done, o_weight_count);
        end
        tick();
        checks++;
        if (o_fetch_done !== 1'b0 || o_busy !== 1'b0 || fifo_q.size() != 1) begin
            errors++;
            $display("FAIL empty_idle: done=%0b busy=%0b fifo=%0d required 0/0/1", o_fetch_done, o_busy, fifo_q.size());
        end
        fifo_q.delete();
        push_spike(5);
        run_fetch("drain_push", FANOUT);
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        ready_mode = 0;
        xfers = 0;
        push_spike(10);
        push_spike(20);
        push_spike(30);
        tick();
        i_start_fetch = 1'b1;
        tick();
        i_start_fetch = 1'b0;
        while (xfers < 5 && waited < 500) begin
            tick();
            waited++;
        end
        checks++;
        if (xfers < 5) begin
            errors++;
            $display("FAIL mid_progress: xfers=%0d required 5", xfers);
        end
        mon_en = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL mid_reset: got %h required 0", all_outs());
        end
        exp_w.delete();
        exp_addr.delete();
        fifo_q.delete();
        fifo_refresh();
        repeat (MEM_LAT + 2) tick();
        checks++;
        if (all_outs() !== '0) begin
            errors++;
            $display("FAIL mid_flush: got %h required 0", all_outs());
        end
        mon_en = 1'b1;
        push_spike(7);
        run_fetch("after_reset", FANOUT);
    endtask

    task automatic test_zero_weight();
        ready_mode = 0;
        zero_addr = 41;
        push_spike(10);
`ifdef SYN_SKIP_ZERO_EN
        run_fetch("zero", 3);
`else
        run_fetch("zero", 4);
`endif
        zero_addr = -1;
    endtask

    task automatic test_addr_wrap();
        ready_mode = 2;
        push_spike(4100);
        push_spike(16383);
        run_fetch("wrap", exp_w.size());
        ready_mode = 0;
    endtask

    task automatic test_random();
        ready_mode = 2;
        for (int k = 0; k < 6; k++) push_spike(int'($urandom_range(0, (1 << PRE_WIDTH) - 1)));
        run_fetch("random", exp_w.size());
        ready_mode = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_start();
        test_reset_mid();
        test_zero_weight();
        test_addr_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
